// File: rtl/ps2_pkg.sv
// Shared constants, decode states and frame check for the PS/2 keyboard path.
package ps2_pkg;

  localparam logic [7:0] BREAK_PFX = 8'hF0;
  localparam logic [7:0] EXT_PFX   = 8'hE0;
  localparam logic [7:0] LSHIFT    = 8'h12;
  localparam logic [7:0] RSHIFT    = 8'h59;
  localparam logic [7:0] CTRL      = 8'h14;

  localparam int FRAME_LEN = 11;

  // Distance between lowercase and uppercase ASCII letters.
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK
  } dec_state_t;

  // start=0, stop=1, odd parity over data plus parity bit
  function automatic logic frame_ok(input logic [FRAME_LEN-1:0] f);
    return (f[0] == 1'b0) && (f[FRAME_LEN-1] == 1'b1) && (^f[FRAME_LEN-2:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Scan-code set 2 to ASCII for letters and digits; shift selects uppercase,
// shifted digits and every other code map to 0. Purely combinational.
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] scan,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] letter;
  logic [7:0] digit;

  always_comb begin
    letter = 8'h00;
    digit  = 8'h00;
    case (scan)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      8'h45: digit  = "0";
      8'h16: digit  = "1";
      8'h1E: digit  = "2";
      8'h26: digit  = "3";
      8'h25: digit  = "4";
      8'h2E: digit  = "5";
      8'h36: digit  = "6";
      8'h3D: digit  = "7";
      8'h3E: digit  = "8";
      8'h46: digit  = "9";
      default: ;
    endcase
  end

  always_comb begin
    ascii = 8'h00;
    if (letter != 8'h00)
      ascii = shift ? (letter - ASCII_CASE_OFS) : letter;
    else if (!shift)
      ascii = digit;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host receiver with frame validation, partial-frame timeout and
// make/break/modifier decode; outputs settle 2 clk after the stop-bit edge.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic [7:0] count,
  output logic       is_shift,
  output logic       is_ctrl,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_d;
  logic                   data_d;
  logic                   fall;

  // data_d is delayed alongside clk_d so it is the bit present at the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_d     <= 1'b1;
      data_d    <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_d     <= clk_sync[SYNC_STAGES-1];
      data_d    <= data_sync[SYNC_STAGES-1];
      fall      <= clk_d & ~clk_sync[SYNC_STAGES-1];
    end
  end

  logic [FRAME_LEN-2:0] shreg;
  logic [FRAME_LEN-1:0] frame_next;
  logic [3:0]           bit_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 byte_vld;
  logic [7:0]           byte_dat;

  assign frame_next = {data_d, shreg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      byte_vld  <= 1'b0;
      byte_dat  <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        shreg   <= frame_next[FRAME_LEN-1:1];
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          if (frame_ok(frame_next)) begin
            byte_vld <= 1'b1;
            byte_dat <= frame_next[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != '0) begin
        // Saturate at the limit; the next falling edge restarts it.
        if (tmo_cnt == TMO_MAX)
          bit_cnt <= '0;
        else
          tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  dec_state_t state, state_nxt;
  logic [7:0] scan_nxt;
  logic [7:0] count_nxt;
  logic       valid_nxt;
  logic       lshift, rshift, lctrl, rctrl;
  logic       lshift_nxt, rshift_nxt, lctrl_nxt, rctrl_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scan_code <= '0;
      count     <= '0;
      key_valid <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
    end else begin
      state     <= state_nxt;
      scan_code <= scan_nxt;
      count     <= count_nxt;
      key_valid <= valid_nxt;
      lshift    <= lshift_nxt;
      rshift    <= rshift_nxt;
      lctrl     <= lctrl_nxt;
      rctrl     <= rctrl_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    scan_nxt   = scan_code;
    count_nxt  = count;
    valid_nxt  = key_valid;
    lshift_nxt = lshift;
    rshift_nxt = rshift;
    lctrl_nxt  = lctrl;
    rctrl_nxt  = rctrl;
    if (byte_vld) begin
      case (state)
        IDLE: begin
          if (byte_dat == BREAK_PFX)    state_nxt  = BREAK;
          else if (byte_dat == EXT_PFX) state_nxt  = EXT;
          else if (byte_dat == LSHIFT)  lshift_nxt = 1'b1;
          else if (byte_dat == RSHIFT)  rshift_nxt = 1'b1;
          else if (byte_dat == CTRL)    lctrl_nxt  = 1'b1;
          else begin
            // typematic repeat of the held key must not count again
            if (!key_valid || byte_dat != scan_code) begin
              count_nxt = count + 8'd1;
              scan_nxt  = byte_dat;
            end
            valid_nxt = 1'b1;
          end
        end
        BREAK: begin
          if (byte_dat == LSHIFT)          lshift_nxt = 1'b0;
          else if (byte_dat == RSHIFT)     rshift_nxt = 1'b0;
          else if (byte_dat == CTRL)       lctrl_nxt  = 1'b0;
          else if (byte_dat == scan_code)  valid_nxt  = 1'b0;
          state_nxt = IDLE;
        end
        EXT: begin
          if (byte_dat == CTRL) rctrl_nxt = 1'b1;
          state_nxt = (byte_dat == BREAK_PFX) ? EXT_BREAK : IDLE;
        end
        EXT_BREAK: begin
          if (byte_dat == CTRL) rctrl_nxt = 1'b0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign is_shift = lshift | rshift;
  assign is_ctrl  = lctrl | rctrl;

  logic [7:0] lut_ascii;

  ps2_ascii_lut u_lut (
    .scan  (scan_code),
    .shift (is_shift),
    .ascii (lut_ascii)
  );

  assign ascii_code = key_valid ? lut_ascii : 8'h00;

endmodule
